// File: rtl/irq_ctrl_pkg.sv
// Shared register map, FSM state encoding and CAUSE field layout for irq_ctrl.
package irq_ctrl_pkg;

  localparam logic [31:0] OFF_MASK    = 32'h0;
  localparam logic [31:0] OFF_PENDING = 32'h4;
  localparam logic [31:0] OFF_CAUSE   = 32'h8;
  localparam logic [31:0] OFF_COUNT   = 32'hC;

  localparam int CAUSE_VALID_BIT = 31;
  localparam int CAUSE_IDX_W     = 3;
  localparam int COUNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  function automatic logic [31:0] cause_word(input logic valid,
                                             input logic [CAUSE_IDX_W-1:0] idx);
    logic [31:0] w;
    w = '0;
    w[CAUSE_VALID_BIT] = valid;
    w[CAUSE_IDX_W-1:0] = idx;
    return w;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: lowest set index wins, index 0 highest.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req_i,
  output logic [CAUSE_IDX_W-1:0] idx_o,
  output logic                   vld_o
);

  // Scanning downward lets the lowest set bit be the last assignment.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = i[CAUSE_IDX_W-1:0];
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller with MASK/PENDING/CAUSE/COUNT registers and IDLE/REQ/SERVICE handshake.
// Build option IRQ_CTRL_COUNT_EN adds a saturating 16-bit serviced-interrupt counter.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             core,
  input  logic             mem_wr,
  input  logic             mem_rd,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  state_e                 state_q, state_d;
  logic [N_SRC-1:0]       src_q, pend_q, pend_d, mask_q, mask_d, w1c, active;
  logic                   cause_vld_q, cause_vld_d;
  logic [CAUSE_IDX_W-1:0] cause_idx_q, cause_idx_d, win_idx;
  logic                   irq_q, irq_d;
  logic                   win_vld;
  logic [31:0]            off, count_rd;
  logic                   unused_wdata;

  assign off          = addr - BASE_ADDR;
  assign w1c          = (mem_wr && off == OFF_PENDING) ? wdata[N_SRC-1:0] : '0;
  // New edges are OR-ed in after the clear so a same-cycle set wins.
  assign pend_d       = (pend_q & ~w1c) | (irq_src & ~src_q);
  assign mask_d       = (mem_wr && off == OFF_MASK) ? wdata[N_SRC-1:0] : mask_q;
  assign active       = pend_q & mask_q;
  assign unused_wdata = ^wdata;
  assign irq          = irq_q;

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .req_i (active),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  always_comb begin
    state_d     = state_q;
    irq_d       = irq_q;
    cause_vld_d = cause_vld_q;
    cause_idx_d = cause_idx_q;
    case (state_q)
      IDLE: begin
        if (win_vld && !core) begin
          state_d     = REQ;
          irq_d       = 1'b1;
          cause_vld_d = 1'b1;
          cause_idx_d = win_idx;
        end
      end
      // MASK changes are ignored here: a raised request always completes.
      REQ: begin
        if (core) begin
          state_d = SERVICE;
          irq_d   = 1'b0;
        end
      end
      SERVICE: begin
        if (!core) begin
          state_d     = IDLE;
          cause_vld_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      cause_vld_q <= 1'b0;
      cause_idx_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= irq_src;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      cause_vld_q <= cause_vld_d;
      cause_idx_q <= cause_idx_d;
      irq_q       <= irq_d;
    end
  end

`ifdef IRQ_CTRL_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == REQ && core && count_q != '1) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_rd = 32'(count_q);
`else
  assign count_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    if (mem_rd) begin
      case (off)
        OFF_MASK:    rdata = 32'(mask_q);
        OFF_PENDING: rdata = 32'(pend_q);
        OFF_CAUSE:   rdata = cause_word(cause_vld_q, cause_idx_q);
        OFF_COUNT:   rdata = count_rd;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized and directed bench for irq_ctrl against a cycle-level behavioural model.
module tb_irq_ctrl;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h4000_0030;
  localparam int          NM   = (1 << N) - 1;
`ifdef IRQ_CTRL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] irq_src = '0;
  logic         core = 1'b0;
  logic         mem_wr = 1'b0;
  logic         mem_rd = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         irq;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .core    (core),
    .mem_wr  (mem_wr),
    .mem_rd  (mem_rd),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = request raised, 2 = handler running.
  int m_src, m_pend, m_mask, m_phase, m_ci, m_count;
  bit m_cv, m_irq;

  function automatic int lowest_index(input int v);
    int low;
    low = v & -v;
    for (int b = 0; b < 8; b++) if (low == (1 << b)) return b;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_src = 0; m_pend = 0; m_mask = 0; m_phase = 0;
      m_ci = 0; m_count = 0; m_cv = 0; m_irq = 0;
    end else begin : model_step
      int act, w1c, edges;
      act   = m_pend & m_mask;
      w1c   = (mem_wr && addr == BASE + 32'h4) ? (int'(wdata) & NM) : 0;
      edges = int'(irq_src) & ~m_src & NM;
      if (m_phase == 0 && act != 0 && !core) begin
        m_phase = 1; m_cv = 1; m_ci = lowest_index(act);
      end else if (m_phase == 1 && core) begin
        m_phase = 2;
        if (CNT_EN && m_count < 65535) m_count++;
      end else if (m_phase == 2 && !core) begin
        m_phase = 0; m_cv = 0;
      end
      m_pend = (m_pend & ~w1c) | edges;
      if (mem_wr && addr == BASE) m_mask = int'(wdata) & NM;
      m_src = int'(irq_src);
      m_irq = (m_phase == 1);
    end
  end

  function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (!rd) return 32'd0;
    case (off)
      32'h0:   return 32'(m_mask);
      32'h4:   return 32'(m_pend);
      32'h8:   return {m_cv, 28'd0, 3'(m_ci)};
      32'hC:   return 32'(m_count);
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      chk("rdata", rdata, m_read(mem_rd, addr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    mem_wr = 1'b1; addr = BASE + off; wdata = d;
    cyc();
    mem_wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] off, input logic [31:0] exp);
    mem_rd = 1'b1; addr = BASE + off;
    #1;
    chk(nm, rdata, exp);
    mem_rd = 1'b0; addr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  int offs[7] = '{0, 4, 8, 12, 16, 2, -4};

  initial begin
    #2;
    reset = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("reset_irq", {31'd0, irq}, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    rd_chk("reset_mask", 32'h0, 32'd0);
    rd_chk("reset_pend", 32'h4, 32'd0);
    rd_chk("reset_cause", 32'h8, 32'd0);
    rd_chk("reset_count", 32'hC, 32'd0);

    // Single masked-in source: edge -> pending -> irq.
    wr(32'h0, 32'h2);
    cyc();
    irq_src = 4'b0010;
    cyc();
    irq_src = '0;
    rd_chk("s1_pend", 32'h4, 32'h2);
    chk("s1_irq_early", {31'd0, irq}, 32'd0);
    cyc();
    chk("s1_irq", {31'd0, irq}, 32'd1);
    rd_chk("s1_cause", 32'h8, 32'h8000_0001);
    core = 1'b1;
    cyc();
    chk("s1_svc_irq", {31'd0, irq}, 32'd0);
    wr(32'h4, 32'h2);
    core = 1'b0;
    cyc();
    rd_chk("s1_cause_ret", 32'h8, 32'h0000_0001);
    cyc();
    chk("s1_idle_irq", {31'd0, irq}, 32'd0);

    // Two simultaneous edges: index 1 first, then index 3 after return.
    wr(32'h0, 32'hF);
    irq_src = 4'b1010;
    cyc();
    irq_src = '0;
    cyc();
    rd_chk("s2_cause1", 32'h8, 32'h8000_0001);
    core = 1'b1;
    cyc();
    wr(32'h4, 32'h2);
    core = 1'b0;
    cyc();
    rd_chk("s2_pend", 32'h4, 32'h8);
    cyc();
    rd_chk("s2_cause3", 32'h8, 32'h8000_0003);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("s3_hold_irq", {31'd0, irq}, 32'd1);
    end
    wr(32'h0, 32'h0);
    chk("s3_mask_nocancel", {31'd0, irq}, 32'd1);
    core = 1'b1;
    cyc();
    chk("s3_svc_irq", {31'd0, irq}, 32'd0);
    wr(32'h4, 32'h8);
    core = 1'b0;
    cyc();
    cyc();

    // Same-cycle W1C and new edge on bit 0.
    irq_src = 4'b0001;
    cyc();
    irq_src = '0;
    cyc();
    irq_src = 4'b0001;
    wr(32'h4, 32'h1);
    irq_src = '0;
    rd_chk("s4_set_wins", 32'h4, 32'h1);
    wr(32'h4, 32'h1);
    rd_chk("s4_cleared", 32'h4, 32'h0);

    // Handler running in IDLE holds off a masked-in pending request.
    core = 1'b1;
    irq_src = 4'b0100;
    cyc();
    irq_src = '0;
    wr(32'h0, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s5_held_irq", {31'd0, irq}, 32'd0);
    end
    core = 1'b0;
    cyc();
    chk("s5_irq", {31'd0, irq}, 32'd1);
    rd_chk("s5_cause", 32'h8, 32'h8000_0002);
    core = 1'b1;
    cyc();
    wr(32'h4, 32'h4);
    core = 1'b0;
    cyc();
    cyc();
    rd_chk("s5_count", 32'hC, CNT_EN ? 32'd4 : 32'd0);

    // Counter after three services, then reset in the middle of REQ.
    do_reset();
    wr(32'h0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      irq_src = 4'b0001;
      cyc();
      irq_src = '0;
      cyc();
      chk("s6_irq", {31'd0, irq}, 32'd1);
      core = 1'b1;
      cyc();
      wr(32'h4, 32'h1);
      core = 1'b0;
      cyc();
    end
    rd_chk("s6_count3", 32'hC, CNT_EN ? 32'd3 : 32'd0);
    irq_src = 4'b0001;
    cyc();
    irq_src = '0;
    cyc();
    chk("s6_req_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    #1;
    chk("s6_rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("s6_rst_count", 32'hC, 32'd0);

    // Source held high through reset release registers as an edge.
    irq_src = 4'b0001;
    cyc();
    reset = 1'b0;
    rd_chk("s7_pend_before", 32'h4, 32'h0);
    cyc();
    rd_chk("s7_pend_after", 32'h4, 32'h1);
    irq_src = '0;
    do_reset();

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      int r;
      if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
      if ($urandom_range(0, 7) == 0) core = ~core;
      r = $urandom_range(0, 7);
      mem_wr = (r == 0);
      mem_rd = (r >= 5);
      addr   = BASE + 32'(offs[$urandom_range(0, 6)]);
      wdata  = $urandom;
      reset  = ($urandom_range(0, 499) == 0);
      cyc();
    end
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    reset  = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
